// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for the F/D, D/X, X/M and M/W
// pipeline latches and the PC register. It inserts bubbles for taken
// branches, load-use hazards and multi-cycle mult/div operations in X.
// Optional statistics counters are compiled in with `define PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int LD_STALL_CYCLES = 1,   // bubbles per load-use hazard (1..15)
    parameter int MD_TIMEOUT      = 64   // max mult/div wait before forced release (2..255)
) (
    input  logic        clock,
    input  logic        res,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_uses_rs,
    input  logic        d_uses_rt,
    input  logic        x_is_load,
    input  logic [4:0]  x_rd,
    input  logic        x_is_md,
    input  logic        x_br_taken,
    input  logic        md_ready,
    output logic        md_start,
    output logic        pc_en,
    output logic        fd_en,
    output logic        dx_en,
    output logic        xm_en,
    output logic        mw_en,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_flush,
    output logic        md_timeout
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MD_WAIT  = 2'd2
    } state_t;

    // Last counter values before returning to RUN.
    localparam logic [3:0] LD_LAST = 4'(LD_STALL_CYCLES - 1);
    localparam logic [7:0] MD_LAST = 8'(MD_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  ld_cnt_reg, ld_cnt_next;
    logic [7:0]  md_cnt_reg, md_cnt_next;
    logic        md_timeout_reg, md_timeout_next;
    logic        load_use;

    // Load-use: the load in X writes a non-zero register that D is about to read.
    assign load_use = x_is_load && (x_rd != 5'd0) &&
                      ((d_uses_rs && (d_rs == x_rd)) || (d_uses_rt && (d_rt == x_rd)));

    // Next-state and latch-control decode; outputs are combinational from state and inputs.
    always_comb begin
        state_next      = state_reg;
        ld_cnt_next     = ld_cnt_reg;
        md_cnt_next     = md_cnt_reg;
        md_timeout_next = md_timeout_reg;
        md_start        = 1'b0;
        pc_en           = 1'b1;
        fd_en           = 1'b1;
        dx_en           = 1'b1;
        xm_en           = 1'b1;
        mw_en           = 1'b1;
        fd_flush        = 1'b0;
        dx_flush        = 1'b0;
        xm_flush        = 1'b0;

        if (!res) begin
            // While in reset every latch is frozen and loaded with a bubble.
            pc_en           = 1'b0;
            fd_en           = 1'b0;
            dx_en           = 1'b0;
            xm_en           = 1'b0;
            mw_en           = 1'b0;
            fd_flush        = 1'b1;
            dx_flush        = 1'b1;
            xm_flush        = 1'b1;
            state_next      = RUN;
            ld_cnt_next     = 4'd0;
            md_cnt_next     = 8'd0;
            md_timeout_next = 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (x_br_taken) begin
                        // Squash the two wrong-path instructions in F/D and D/X.
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (x_is_md) begin
                        // Hold the front end and the mult/div in X; bubble into X/M.
                        md_start    = 1'b1;
                        pc_en       = 1'b0;
                        fd_en       = 1'b0;
                        dx_en       = 1'b0;
                        xm_flush    = 1'b1;
                        state_next  = MD_WAIT;
                        md_cnt_next = 8'd1;
                    end else if (load_use) begin
                        // Hold PC and F/D; insert a bubble into D/X.
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        dx_flush = 1'b1;
                        if (LD_STALL_CYCLES > 1) begin
                            state_next  = LD_STALL;
                            ld_cnt_next = 4'd1;
                        end
                    end
                end

                LD_STALL: begin
                    pc_en       = 1'b0;
                    fd_en       = 1'b0;
                    dx_flush    = 1'b1;
                    ld_cnt_next = ld_cnt_reg + 4'd1;
                    if (ld_cnt_reg == LD_LAST) begin
                        state_next  = RUN;
                        ld_cnt_next = 4'd0;
                    end
                end

                MD_WAIT: begin
                    if (md_ready) begin
                        // Result is latched into X/M this edge; all enables open.
                        state_next  = RUN;
                        md_cnt_next = 8'd0;
                    end else if (md_cnt_reg == MD_LAST) begin
                        // The unit never answered: release anyway and remember it.
                        state_next      = RUN;
                        md_cnt_next     = 8'd0;
                        md_timeout_next = 1'b1;
                    end else begin
                        pc_en       = 1'b0;
                        fd_en       = 1'b0;
                        dx_en       = 1'b0;
                        xm_flush    = 1'b1;
                        md_cnt_next = md_cnt_reg + 8'd1;
                    end
                end

                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!res) begin
            state_reg      <= RUN;
            ld_cnt_reg     <= 4'd0;
            md_cnt_reg     <= 8'd0;
            md_timeout_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ld_cnt_reg     <= ld_cnt_next;
            md_cnt_reg     <= md_cnt_next;
            md_timeout_reg <= md_timeout_next;
        end
    end

    assign md_timeout = md_timeout_reg;

`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Count stalled-PC cycles and F/D flush cycles outside reset; both wrap.
    always_ff @(posedge clock) begin
        if (!res) begin
            stall_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
        end else begin
            if (!pc_en) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (fd_flush) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: two instances (LD_STALL_CYCLES=2/MD_TIMEOUT=8
// and LD_STALL_CYCLES=1/MD_TIMEOUT=5) share randomized stimulus. A reference
// model built on remaining-bubble and wait-cycle counts pushes expected outputs
// into per-instance queues; a monitor pops and compares on the falling edge.
// Statistics ports are checked when PIPE_HAZARD_STATS_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int LD_A = 2;
    localparam int TO_A = 8;
    localparam int LD_B = 1;
    localparam int TO_B = 5;
    localparam int NUM_CYCLES = 4000;

    typedef struct packed {
        logic [8:0]  outs;   // {md_start, pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush}
        logic        to;
        logic        known;
        logic [31:0] st;
        logic [31:0] fl;
    } exp_t;

    logic        clock;
    logic        res;
    logic [4:0]  d_rs, d_rt, x_rd;
    logic        d_uses_rs, d_uses_rt, x_is_load, x_is_md, x_br_taken, md_ready;

    logic        md_start_a, pc_en_a, fd_en_a, dx_en_a, xm_en_a, mw_en_a;
    logic        fd_flush_a, dx_flush_a, xm_flush_a, md_timeout_a;
    logic        md_start_b, pc_en_b, fd_en_b, dx_en_b, xm_en_b, mw_en_b;
    logic        fd_flush_b, dx_flush_b, xm_flush_b, md_timeout_b;
    logic [8:0]  outs_a, outs_b;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks;
    int   failures;
    bit   stim_done;

    // Reference model state, one slot per instance.
    int          ld_left[2];
    bit          md_busy[2];
    int          waited[2];
    bit          to_flag[2];
    bit          known[2];
    logic [31:0] stalls[2];
    logic [31:0] flushes[2];

    pipe_hazard_ctrl #(.LD_STALL_CYCLES(LD_A), .MD_TIMEOUT(TO_A)) dut_a (
        .clock(clock), .res(res),
        .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
        .x_is_load(x_is_load), .x_rd(x_rd), .x_is_md(x_is_md),
        .x_br_taken(x_br_taken), .md_ready(md_ready),
        .md_start(md_start_a), .pc_en(pc_en_a), .fd_en(fd_en_a), .dx_en(dx_en_a),
        .xm_en(xm_en_a), .mw_en(mw_en_a), .fd_flush(fd_flush_a), .dx_flush(dx_flush_a),
        .xm_flush(xm_flush_a), .md_timeout(md_timeout_a)
`ifdef PIPE_HAZARD_STATS_EN
        , .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
`endif
    );

    pipe_hazard_ctrl #(.LD_STALL_CYCLES(LD_B), .MD_TIMEOUT(TO_B)) dut_b (
        .clock(clock), .res(res),
        .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
        .x_is_load(x_is_load), .x_rd(x_rd), .x_is_md(x_is_md),
        .x_br_taken(x_br_taken), .md_ready(md_ready),
        .md_start(md_start_b), .pc_en(pc_en_b), .fd_en(fd_en_b), .dx_en(dx_en_b),
        .xm_en(xm_en_b), .mw_en(mw_en_b), .fd_flush(fd_flush_b), .dx_flush(dx_flush_b),
        .xm_flush(xm_flush_b), .md_timeout(md_timeout_b)
`ifdef PIPE_HAZARD_STATS_EN
        , .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
`endif
    );

    assign outs_a = {md_start_a, pc_en_a, fd_en_a, dx_en_a, xm_en_a, mw_en_a,
                     fd_flush_a, dx_flush_a, xm_flush_a};
    assign outs_b = {md_start_b, pc_en_b, fd_en_b, dx_en_b, xm_en_b, mw_en_b,
                     fd_flush_b, dx_flush_b, xm_flush_b};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One cycle of the reference model for instance k; returns the expected outputs.
    task automatic model_step(input int k, input int ld_cycles, input int md_to, output exp_t e);
        bit start, pc, fd, dx, xm, mw, ff, df, xf, hazard;
        e.to    = to_flag[k];
        e.known = known[k];
        e.st    = stalls[k];
        e.fl    = flushes[k];
        start = 0; pc = 1; fd = 1; dx = 1; xm = 1; mw = 1; ff = 0; df = 0; xf = 0;
        hazard = x_is_load && (x_rd != 0) &&
                 ((d_uses_rs && d_rs == x_rd) || (d_uses_rt && d_rt == x_rd));
        if (!res) begin
            pc = 0; fd = 0; dx = 0; xm = 0; mw = 0; ff = 1; df = 1; xf = 1;
            ld_left[k] = 0; md_busy[k] = 0; waited[k] = 0; to_flag[k] = 0;
            stalls[k] = 0; flushes[k] = 0; known[k] = 1;
        end else begin
            if (ld_left[k] > 0) begin
                pc = 0; fd = 0; df = 1;
                ld_left[k] = ld_left[k] - 1;
            end else if (md_busy[k]) begin
                if (md_ready || waited[k] == md_to - 2) begin
                    if (!md_ready) to_flag[k] = 1;
                    md_busy[k] = 0;
                    $display("TXN dut%0d mult/div released after %0d wait cycles, forced=%0d",
                             k, waited[k] + 1, !md_ready);
                end else begin
                    pc = 0; fd = 0; dx = 0; xf = 1;
                    waited[k] = waited[k] + 1;
                end
            end else if (x_br_taken) begin
                ff = 1; df = 1;
            end else if (x_is_md) begin
                start = 1; pc = 0; fd = 0; dx = 0; xf = 1;
                md_busy[k] = 1;
                waited[k] = 0;
            end else if (hazard) begin
                pc = 0; fd = 0; df = 1;
                ld_left[k] = ld_cycles - 1;
            end
            if (!pc) stalls[k] = stalls[k] + 32'd1;
            if (ff) flushes[k] = flushes[k] + 32'd1;
        end
        e.outs = {start, pc, fd, dx, xm, mw, ff, df, xf};
    endtask

    task automatic check_one(input string name, input exp_t e, input logic [8:0] outs,
                             input logic to, input logic [31:0] st, input logic [31:0] fl);
        checks++;
        if (outs !== e.outs) begin
            failures++;
            $display("FAIL %s outputs: got %b expected %b at %0t", name, outs, e.outs, $time);
        end
        if (e.known) begin
            checks++;
            if (to !== e.to) begin
                failures++;
                $display("FAIL %s md_timeout: got %b expected %b at %0t", name, to, e.to, $time);
            end
`ifdef PIPE_HAZARD_STATS_EN
            checks++;
            if (st !== e.st) begin
                failures++;
                $display("FAIL %s stall_cnt: got %0d expected %0d at %0t", name, st, e.st, $time);
            end
            checks++;
            if (fl !== e.fl) begin
                failures++;
                $display("FAIL %s flush_cnt: got %0d expected %0d at %0t", name, fl, e.fl, $time);
            end
`endif
        end
    endtask

    // Monitor: compares the DUT outputs against queued expectations mid-cycle.
    initial begin
        exp_t e;
        logic [31:0] st_a, fl_a, st_b, fl_b;
        forever begin
            @(negedge clock);
`ifdef PIPE_HAZARD_STATS_EN
            st_a = stall_cnt_a; fl_a = flush_cnt_a; st_b = stall_cnt_b; fl_b = flush_cnt_b;
`else
            st_a = '0; fl_a = '0; st_b = '0; fl_b = '0;
`endif
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check_one("dut_a", e, outs_a, md_timeout_a, st_a, fl_a);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check_one("dut_b", e, outs_b, md_timeout_b, st_b, fl_b);
            end
        end
    end

    task automatic issue_cycle();
        exp_t ea, eb;
        model_step(0, LD_A, TO_A, ea);
        model_step(1, LD_B, TO_B, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    // Stimulus: directed reset with x_is_md held, then randomized phases.
    initial begin
        int ready_pct;
        checks = 0; failures = 0; stim_done = 0;
        for (int k = 0; k < 2; k++) begin
            ld_left[k] = 0; md_busy[k] = 0; waited[k] = 0; to_flag[k] = 0;
            known[k] = 0; stalls[k] = 0; flushes[k] = 0;
        end
        res = 0; d_rs = 0; d_rt = 0; x_rd = 0; d_uses_rs = 0; d_uses_rt = 0;
        x_is_load = 0; x_is_md = 1; x_br_taken = 0; md_ready = 0;

        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            issue_cycle();
        end

        for (int c = 0; c < NUM_CYCLES; c++) begin
            @(posedge clock); #1;
            ready_pct  = (c < NUM_CYCLES / 2) ? 30 : 6;
            res        = ($urandom_range(0, 99) >= 2);
            d_rs       = 5'($urandom_range(0, 3));
            d_rt       = 5'($urandom_range(0, 3));
            x_rd       = 5'($urandom_range(0, 3));
            d_uses_rs  = ($urandom_range(0, 99) < 60);
            d_uses_rt  = ($urandom_range(0, 99) < 60);
            x_is_load  = ($urandom_range(0, 99) < 40);
            x_is_md    = ($urandom_range(0, 99) < 12);
            x_br_taken = ($urandom_range(0, 99) < 10);
            md_ready   = ($urandom_range(0, 99) < ready_pct);
            issue_cycle();
        end
        stim_done = 1;

        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL drain: queues hold %0d/%0d entries, required 0/0", q_a.size(), q_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
